jpeg_quant: RTL

//  Quantizer stage of the JPEG DCT accelerator. Consumes 8x8 coefficient blocks one row
//  (8 coefficients) per beat from the column-pass DCT behind the transpose buffer.

---
 rtl/jpeg_pkg.sv | 17 +
 rtl/jpeg_quant_lane.sv | 55 +++++
 rtl/jpeg_quant.sv | 88 ++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// Shared widths and row types for the JPEG quantizer stage.
package jpeg_pkg;

    localparam int unsigned IN_W    = 12;
    localparam int unsigned OUT_W   = 12;
    localparam int unsigned RECIP_W = 16;
    localparam int unsigned SHIFT   = 15;
    localparam int unsigned PROD_W  = IN_W + RECIP_W + 1;

    typedef logic [7:0][IN_W-1:0]  coef_row_t;
    typedef logic [7:0][OUT_W-1:0] qrow_t;
    typedef logic [RECIP_W-1:0]    recip_t;

    // Reciprocal of Q=1, i.e. pass-through.
    localparam recip_t RECIP_ONE = recip_t'(1 << SHIFT);

endpackage

// File: rtl/jpeg_quant_lane.sv
// One quantizer lane: signed coefficient times unsigned reciprocal (S1),
// then round-half-up and saturate into the output register (S2).
module jpeg_quant_lane
    import jpeg_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [IN_W-1:0] coef,
    input  recip_t          recip,
    output logic [OUT_W-1:0] q
);

    localparam int unsigned R_W = PROD_W - SHIFT + 1;
    localparam logic signed [R_W-1:0] SAT_MAX = R_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [R_W-1:0] SAT_MIN = R_W'(-(2 ** (OUT_W - 1)));

    logic signed [PROD_W-1:0] coef_ext;
    logic signed [PROD_W-1:0] recip_ext;
    logic signed [PROD_W-1:0] prod_d;
    logic signed [PROD_W-1:0] prod_q;
    logic        [PROD_W:0]   rounded;
    logic signed [R_W-1:0]    r;
    logic        [OUT_W-1:0]  q_d;

    always_comb begin
        coef_ext  = PROD_W'($signed(coef));
        recip_ext = PROD_W'({1'b0, recip});
        prod_d    = coef_ext * recip_ext;
    end

    // One guard bit so adding the half-LSB cannot wrap.
    always_comb begin
        rounded = {prod_q[PROD_W-1], prod_q} + (PROD_W + 1)'(1 << (SHIFT - 1));
        r       = $signed(rounded[PROD_W:SHIFT]);
        if (r > SAT_MAX) begin
            q_d = SAT_MAX[OUT_W-1:0];
        end else if (r < SAT_MIN) begin
            q_d = SAT_MIN[OUT_W-1:0];
        end else begin
            q_d = r[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            q      <= '0;
        end else if (en) begin
            prod_q <= prod_d;
            q      <= q_d;
        end
    end

endmodule

// File: rtl/jpeg_quant.sv
// Quantizer top: reciprocal table, row counter and two-stage valid/ready pipeline
// feeding eight multiply/round/saturate lanes.
module jpeg_quant
    import jpeg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       in_valid,
    output logic       in_ready,
    input  coef_row_t  in_data,
    input  logic       q_we,
    input  logic [5:0] q_addr,
    input  recip_t     q_data,
    output logic       out_valid,
    input  logic       out_ready,
    output qrow_t      out_data,
    output logic [2:0] out_row,
    output logic       out_last
);

    recip_t     table_q [64];
    logic [2:0] row_q;
    logic [2:0] s1_row_q;
    logic       s1_valid_q;
    logic       en;
    logic       accept;

    always_comb begin
        en       = ~out_valid | out_ready;
        in_ready = en;
        accept   = in_valid & en & ~clr;
        out_last = (out_row == 3'd7);
    end

    // Lanes read the table before this edge's write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                table_q[i] <= RECIP_ONE;
            end
        end else if (q_we) begin
            table_q[q_addr] <= q_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= 3'd0;
        end else if (clr) begin
            row_q <= 3'd0;
        end else if (accept) begin
            row_q <= row_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_row_q   <= 3'd0;
            out_valid  <= 1'b0;
            out_row    <= 3'd0;
        end else if (clr) begin
            s1_valid_q <= 1'b0;
            out_valid  <= 1'b0;
        end else if (en) begin
            s1_valid_q <= accept;
            s1_row_q   <= row_q;
            out_valid  <= s1_valid_q;
            out_row    <= s1_row_q;
        end
    end

    for (genvar k = 0; k < 8; k++) begin : g_lane
        recip_t recip_k;
        assign recip_k = table_q[{row_q, 3'(k)}];

        jpeg_quant_lane u_lane (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .coef  (in_data[k]),
            .recip (recip_k),
            .q     (out_data[k])
        );
    end

endmodule
